// File: rtl/triangle_pkg.sv
// Shared types and constants for the triangle job scheduler.
// Job packing is {p1x,p1y,p2x,p2y,p3x,p3y,ptx,pty}, p1x in the MSBs.
package triangle_pkg;

  localparam int COORD_W = 11;
  localparam int JOB_W   = 8 * COORD_W;

  localparam int P1X_OFF = 7 * COORD_W;
  localparam int P1Y_OFF = 6 * COORD_W;
  localparam int P2X_OFF = 5 * COORD_W;
  localparam int P2Y_OFF = 4 * COORD_W;
  localparam int P3X_OFF = 3 * COORD_W;
  localparam int P3Y_OFF = 2 * COORD_W;
  localparam int PTX_OFF = 1 * COORD_W;
  localparam int PTY_OFF = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/triangle_job_scheduler_if.sv
// Requester, tester and status bundle of the job scheduler.
// slave = scheduler side, master = requesters plus tester side.
interface triangle_job_scheduler_if
  import triangle_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int COORD_W = triangle_pkg::COORD_W
);

  localparam int JW = 8 * COORD_W;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*JW-1:0] req_data;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_inside;
  logic               rsp_timeout;
  logic [JW-1:0]      t_coords;
  logic               t_active;
  logic               t_value;
  logic               busy;
  logic [15:0]        job_count;

  modport slave (
    input  req_valid, req_data,
    input  t_active, t_value,
    output req_ready, rsp_valid,
    output rsp_inside, rsp_timeout,
    output t_coords, busy, job_count
  );

  modport master (
    output req_valid, req_data,
    output t_active, t_value,
    input  req_ready, rsp_valid,
    input  rsp_inside, rsp_timeout,
    input  t_coords, busy, job_count
  );

endinterface

// File: rtl/triangle_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search from i_ptr upward with wrap.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_any   = 1'b1;
        o_idx   = IW'((int'(i_ptr) + k) % NREQ);
        o_grant[(int'(i_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/triangle_job_scheduler.sv
// Round-robin scheduler sharing one point-in-triangle tester
// among NREQ requesters, with a WAIT timeout guard.
module triangle_job_scheduler
  import triangle_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int COORD_W = triangle_pkg::COORD_W,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  triangle_job_scheduler_if.slave bus
);

  localparam int JW = 8 * COORD_W;
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [JW-1:0]   r_job;
  logic [TW-1:0]   r_timer;
  logic [NREQ-1:0] r_rsp_valid;
  logic            r_inside;
  logic            r_timeout;
  logic            r_busy;
  logic [15:0]     r_cnt;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_tmo;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_rsp_valid;
  logic            w_inside;
  logic            w_timeout;
  logic            w_busy;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_tmo = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|bus.req_valid) w_next = S_GRANT;
      S_GRANT: w_next = w_any ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  if (bus.t_active || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A live result in the final WAIT cycle beats the timeout.
  always_comb begin
    w_ready     = (r_state == S_GRANT) ? w_grant : '0;
    w_rsp_valid = '0;
    w_inside    = 1'b0;
    w_timeout   = 1'b0;
    w_busy      = (w_next != S_IDLE);
    if (r_state == S_WAIT && w_next == S_RESP) begin
      w_rsp_valid = NREQ'(1) << r_id;
      w_inside    = bus.t_active & bus.t_value;
      w_timeout   = ~bus.t_active;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_job       <= '0;
      r_timer     <= '0;
      r_rsp_valid <= '0;
      r_inside    <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= w_rsp_valid;
      r_inside    <= w_inside;
      r_timeout   <= w_timeout;
      r_busy      <= w_busy;
      if (r_state == S_GRANT && w_any) begin
        r_job <= bus.req_data[int'(w_idx)*JW +: JW];
        r_id  <= w_idx;
        r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == S_LOAD)      r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
      if (r_state == S_RESP)      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_inside  = r_inside;
  assign bus.rsp_timeout = r_timeout;
  assign bus.t_coords    = r_job;
  assign bus.busy        = r_busy;
  assign bus.job_count   = r_cnt;

endmodule
